// File: rtl/index_register.sv
// rtl/index_register.sv - scratch-pad index register file (16 x 4-bit) on a shared bidirectional bus
//
// Purpose:
//   Sixteen 4-bit index registers (R0..R15) for a 4004-style datapath. A
//   2-bit IO code selects LOAD from the bus, READ onto the bus, INC of the
//   addressed register, or IDLE. LOAD and INC are qualified by a write enable
//   and take effect on the rising clock edge; READ drives the bus
//   combinationally with no write-through bypass.
//
// Optional feature:
//   INDEX_REGISTER_ZERO_FLAG_EN - adds index_register_zero, a combinational
//   flag that is 1 when the addressed register holds 4'h0.
//
// Ports:
//   clk                    in     1  rising-edge clock
//   reset_n                in     1  synchronous active-low reset, clears all registers
//   index_register_select  in     4  register address 0..15
//   index_register_IO      in     2  00 LOAD, 01 READ, 10 INC, 11 IDLE
//   index_register_I_WE    in     1  write enable for LOAD and INC
//   data_bus               inout  4  driven only during READ, otherwise high-Z
//   index_register_zero    out    1  (INDEX_REGISTER_ZERO_FLAG_EN only) reg[select] == 0

module index_register (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] index_register_select,
  input  logic [1:0] index_register_IO,
  input  logic       index_register_I_WE,
`ifdef INDEX_REGISTER_ZERO_FLAG_EN
  inout  wire  [3:0] data_bus,
  output logic       index_register_zero
`else
  inout  wire  [3:0] data_bus
`endif
);

  logic [15:0][3:0] regs_q;
  logic [15:0][3:0] regs_d;

  logic       sel_valid;
  logic       load_op;
  logic       read_op;
  logic       inc_op;
  logic [3:0] rd_data;

  // Explicit enumeration so an X/Z address falls to the default arm and
  // suppresses both the bus driver and any register write.
  always_comb begin
    sel_valid = 1'b0;
    case (index_register_select)
      4'h0, 4'h1, 4'h2, 4'h3,
      4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hA, 4'hB,
      4'hC, 4'hD, 4'hE, 4'hF: sel_valid = 1'b1;
      default:                sel_valid = 1'b0;
    endcase
  end

  // An unknown IO code matches no arm and therefore behaves as IDLE.
  always_comb begin
    load_op = 1'b0;
    read_op = 1'b0;
    inc_op  = 1'b0;
    case (index_register_IO)
      2'b00:   load_op = 1'b1;
      2'b01:   read_op = 1'b1;
      2'b10:   inc_op  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (sel_valid && index_register_I_WE) begin
      if (load_op) begin
        regs_d[index_register_select] = data_bus;
      end else if (inc_op) begin
        // 4-bit add wraps F -> 0; no carry out is kept.
        regs_d[index_register_select] = regs_q[index_register_select] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read path comes straight from the flops, so a same-cycle write is not
  // visible until after the edge, and reset does not gate it.
  assign rd_data  = regs_q[index_register_select];
  assign data_bus = (read_op && sel_valid) ? rd_data : 4'bzzzz;

`ifdef INDEX_REGISTER_ZERO_FLAG_EN
  assign index_register_zero = (regs_q[index_register_select] == 4'h0);
`endif

endmodule

// File: tb/tb_index_register.sv
// tb/tb_index_register.sv - self-checking bench for index_register against a behavioural array model

module tb_index_register;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sel;
  logic [1:0] io;
  logic       we;
  logic       drv_en;
  logic [3:0] drv_val;
  wire  [3:0] data_bus;
`ifdef INDEX_REGISTER_ZERO_FLAG_EN
  logic       zero;
`endif

  int checks = 0;
  int errors = 0;
  int model [16];

  always #5 clk = ~clk;

  assign data_bus = drv_en ? drv_val : 4'bzzzz;

  index_register dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .index_register_select (sel),
    .index_register_IO     (io),
    .index_register_I_WE   (we),
`ifdef INDEX_REGISTER_ZERO_FLAG_EN
    .data_bus              (data_bus),
    .index_register_zero   (zero)
`else
    .data_bus              (data_bus)
`endif
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

`ifdef INDEX_REGISTER_ZERO_FLAG_EN
  task automatic check_zero(input string tag, input int a);
    logic exp_z;
    exp_z = (model[a] == 0);
    checks++;
    assert (zero === exp_z) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, zero, exp_z);
    end
  endtask
`endif

  // Present inputs; the bench drives the bus in every mode except READ.
  task automatic apply(input logic [1:0] op, input int a, input logic w, input logic [3:0] v);
    io      = op;
    sel     = a[3:0];
    we      = w;
    drv_val = v;
    drv_en  = (op != OP_READ);
  endtask

  // One rising edge, then the model takes the same step from the rules.
  task automatic tick();
    int a;
    @(posedge clk);
    #1;
    a = int'(sel);
    if (!reset_n) begin
      for (int k = 0; k < 16; k++) model[k] = 0;
    end else if (we && io == OP_LOAD) begin
      model[a] = int'(drv_val);
    end else if (we && io == OP_INC) begin
      model[a] = (model[a] + 1) % 16;
    end
  endtask

  task automatic read_check(input int a, input string tag);
    logic [3:0] exp_v;
    apply(OP_READ, a, 1'b0, 4'h0);
    #1;
    exp_v = model[a][3:0];
    check(tag, data_bus, exp_v);
`ifdef INDEX_REGISTER_ZERO_FLAG_EN
    check_zero({tag, "_zero"}, a);
`endif
  endtask

  task automatic op_cycle(input logic [1:0] op, input int a, input logic w, input logic [3:0] v);
    apply(op, a, w, v);
    tick();
    drv_en = 1'b0;
  endtask

  initial begin
    int         a;
    logic [1:0] op;
    logic       w;
    logic [3:0] v;
    logic [3:0] exp_v;

    for (int k = 0; k < 16; k++) model[k] = $urandom_range(0, 15);
    reset_n = 1'b0;
    apply(OP_IDLE, 0, 1'b0, 4'h0);

    // Reset clears everything
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) read_check(i, $sformatf("reset_r%0d", i));

    // Load i into Ri, then read all back
    for (int i = 0; i < 16; i++) op_cycle(OP_LOAD, i, 1'b1, 4'(i));
    for (int i = 0; i < 16; i++) read_check(i, $sformatf("load_r%0d", i));

    // Write-enable gating on R5
    op_cycle(OP_LOAD, 5, 1'b1, 4'hA);
    read_check(5, "preload_r5");
    op_cycle(OP_LOAD, 5, 1'b0, 4'h3);
    read_check(5, "load_we0_r5");
    op_cycle(OP_INC, 5, 1'b0, 4'h0);
    read_check(5, "inc_we0_r5");
    op_cycle(OP_READ, 5, 1'b1, 4'h0);
    read_check(5, "read_we1_r5");
    op_cycle(OP_IDLE, 5, 1'b1, 4'h3);
    read_check(5, "idle_we1_r5");
    read_check(4, "neighbour_r4");
    read_check(6, "neighbour_r6");

    // Increment wrap on R7
    op_cycle(OP_LOAD, 7, 1'b1, 4'hE);
    read_check(7, "r7_e");
    op_cycle(OP_INC, 7, 1'b1, 4'h0);
    read_check(7, "r7_f");
    op_cycle(OP_INC, 7, 1'b1, 4'h0);
    read_check(7, "r7_wrap0");
    read_check(8, "r7_wrap_neighbour");

    // Bus released outside READ: the bench drives 4'hA while R3 holds 4'h5
    op_cycle(OP_LOAD, 3, 1'b1, 4'h5);
    apply(OP_LOAD, 3, 1'b0, 4'hA);
    #1 check("tristate_load", data_bus, 4'hA);
    apply(OP_INC, 3, 1'b0, 4'hA);
    #1 check("tristate_inc", data_bus, 4'hA);
    apply(OP_IDLE, 3, 1'b0, 4'hA);
    #1 check("tristate_idle", data_bus, 4'hA);

    // READ follows select with no clock edge
    apply(OP_READ, 3, 1'b0, 4'h0);
    #1 check("read_follow_r3", data_bus, 4'h5);
    sel = 4'd7;
    #1 check("read_follow_r7", data_bus, 4'h0);
    sel = 4'd12;
    #1 check("read_follow_r12", data_bus, 4'hC);
    tick();

    // Reset wins over a same-cycle LOAD
    reset_n = 1'b0;
    op_cycle(OP_LOAD, 2, 1'b1, 4'h9);
    reset_n = 1'b1;
    read_check(2, "reset_prio_r2");
    read_check(9, "reset_prio_r9");

    // Randomized traffic checked before every edge
    for (int n = 0; n < 400; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 15);
      w  = 1'($urandom_range(0, 1));
      v  = 4'($urandom_range(0, 15));
      reset_n = ($urandom_range(0, 59) != 0);
      apply(op, a, w, v);
      #1;
      if (op == OP_READ) begin
        exp_v = model[a][3:0];
        check($sformatf("rand_read_%0d", n), data_bus, exp_v);
      end else begin
        check($sformatf("rand_bus_%0d", n), data_bus, v);
      end
`ifdef INDEX_REGISTER_ZERO_FLAG_EN
      check_zero($sformatf("rand_zero_%0d", n), a);
`endif
      tick();
      drv_en = 1'b0;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) read_check(i, $sformatf("final_r%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
